truth_table_checker: RTL and testbench

On-board self-checking harness for small combinational lab designs: drives every input combination of an N-input, 1-output DUT, holds each vector for a programmable dwell time, samples the DUT response and compares it against an expected truth table. It is the response/checking end of the stimulus sequence used in simulation, synthesised into the board top next to the DUT (e.g. the `or2` design) with results shown on LEDs.

---
 rtl/truth_table_checker_pkg.sv | 12 +
 rtl/truth_table_checker_dwell_timer.sv | 29 ++
 rtl/truth_table_checker.sv | 122 ++++++++++++
 tb/tb_truth_table_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth table checker.
package ttc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } ttc_state_t;

    localparam int TTC_MIN_DWELL = 2;

endpackage

// File: rtl/truth_table_checker_dwell_timer.sv
// Dwell timer: counts enabled cycles 0..DWELL-1 and flags the last one.
module dwell_timer #(
    parameter int DWELL = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // expire is the cycle on which the caller samples; counter wraps itself
    assign expire = enable && (cnt == LAST);

    // Dwell counter: cleared on reset/clear, wraps to zero after expire
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= expire ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker for a small N-input, 1-output combinational DUT.
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int                  N_IN     = 2,
    parameter int                  DWELL    = 100,
    parameter logic [2**N_IN-1:0]  EXPECTED = 4'b1110
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    // Dwell below the minimum is clamped so the timer always has a real count.
    localparam int EFF_DWELL = (DWELL < TTC_MIN_DWELL) ? TTC_MIN_DWELL : DWELL;
    localparam int ERR_W     = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    ttc_state_t      state, state_next;
    logic [N_IN-1:0] vec, vec_next;
    logic [N_IN:0]   err_next;
    logic            ffv_next;
    logic [N_IN-1:0] ffvec_next;
    logic            busy_next, done_next, pass_next;
    logic            timer_clear, timer_en, expire;

    dwell_timer #(
        .DWELL (EFF_DWELL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    // vec is returned to zero when leaving APPLY, so it drives dut_in directly
    assign dut_in = vec;

    // Next-state, vector stepping and result accumulation
    always_comb begin
        state_next  = state;
        vec_next    = vec;
        err_next    = err_count;
        ffv_next    = first_fail_valid;
        ffvec_next  = first_fail_vec;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = APPLY;
                    vec_next    = '0;
                    err_next    = '0;
                    ffv_next    = 1'b0;
                    ffvec_next  = '0;
                    timer_clear = 1'b1;
                end
            end
            APPLY: begin
                timer_en = 1'b1;
                if (expire) begin
                    if (dut_out != EXPECTED[vec]) begin
                        err_next = err_count + ERR_W'(1);
                        if (!first_fail_valid) begin
                            ffv_next   = 1'b1;
                            ffvec_next = vec;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        state_next = DONE;
                        vec_next   = '0;
                    end else begin
                        vec_next = vec + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                vec_next   = '0;
            end
        endcase

        // Status flags are precomputed from next values so they come out of flops
        busy_next = (state_next == APPLY);
        done_next = (state_next == DONE);
        pass_next = (state_next == DONE) && (err_next == '0);
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_next;
            vec              <= vec_next;
            err_count        <= err_next;
            first_fail_valid <= ffv_next;
            first_fail_vec   <= ffvec_next;
            busy             <= busy_next;
            done             <= done_next;
            pass             <= pass_next;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: 2-input OR config and 3-input XOR config.
module tb_truth_table_checker;

    localparam int D1 = 100;
    localparam int N1 = 4;
    localparam int D2 = 3;
    localparam int N2 = 8;

    localparam logic [1:0] M_OR    = 2'd0;
    localparam logic [1:0] M_AND   = 2'd1;
    localparam logic [1:0] M_STUCK = 2'd2;

    typedef struct {
        logic [2:0] err;
        logic       ffv;
        logic [1:0] ffvec;
        logic       pass;
    } result_t;

    typedef struct {
        logic [1:0] vec;
        logic [2:0] err_before;
    } vec_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start1 = 1'b0;
    logic [1:0] dut_in1;
    logic       dut_out1;
    logic       busy1, done1, pass1, ffv1;
    logic [2:0] err1;
    logic [1:0] ffvec1;
    logic [1:0] mode = M_OR;

    logic       start2 = 1'b0;
    logic [2:0] dut_in2;
    logic       dut_out2;
    logic       busy2, done2, pass2, ffv2;
    logic [3:0] err2;
    logic [2:0] ffvec2;

    int total = 0;
    int bad   = 0;

    result_t    sb_q[$];
    vec_entry_t vec_q[$];

    always #5 clk = ~clk;

    truth_table_checker #(
        .N_IN     (2),
        .DWELL    (D1),
        .EXPECTED (4'b1110)
    ) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .start            (start1),
        .dut_in           (dut_in1),
        .dut_out          (dut_out1),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .err_count        (err1),
        .first_fail_valid (ffv1),
        .first_fail_vec   (ffvec1)
    );

    truth_table_checker #(
        .N_IN     (3),
        .DWELL    (D2),
        .EXPECTED (8'h96)
    ) u_dut2 (
        .clk              (clk),
        .rst              (rst),
        .start            (start2),
        .dut_in           (dut_in2),
        .dut_out          (dut_out2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .err_count        (err2),
        .first_fail_valid (ffv2),
        .first_fail_vec   (ffvec2)
    );

    function automatic logic lab_dut(input logic [1:0] m, input logic [1:0] v);
        case (m)
            M_OR:    return v[0] | v[1];
            M_AND:   return v[0] & v[1];
            default: return 1'b1;
        endcase
    endfunction

    // Lab DUT stand-ins
    always_comb dut_out1 = lab_dut(mode, dut_in1);
    always_comb dut_out2 = ^dut_in2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset1(input string tag);
        check({tag, "_dut_in"}, dut_in1, 0);
        check({tag, "_busy"},   busy1,   0);
        check({tag, "_done"},   done1,   0);
        check({tag, "_pass"},   pass1,   0);
        check({tag, "_err"},    err1,    0);
        check({tag, "_ffv"},    ffv1,    0);
        check({tag, "_ffvec"},  ffvec1,  0);
    endtask

    // Full run on instance 1 with lab DUT mode m against truth table 4'b1110
    task automatic run1(input logic [1:0] m);
        logic [3:0] tt;
        result_t    r;
        vec_entry_t e;
        tt    = 4'b1110;
        r.err = 0; r.ffv = 0; r.ffvec = 0;
        for (int v = 0; v < N1; v++) begin
            e.vec        = 2'(v);
            e.err_before = r.err;
            vec_q.push_back(e);
            if (lab_dut(m, 2'(v)) != tt[v]) begin
                if (!r.ffv) r.ffvec = 2'(v);
                r.ffv = 1'b1;
                r.err = r.err + 3'd1;
            end
        end
        r.pass = (r.err == 0);
        sb_q.push_back(r);

        mode   = m;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 0; k <= N1 * D1; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 0) begin
                check("e0_busy", busy1, 1);
                check("e0_done", done1, 0);
                check("e0_ffv",  ffv1,  0);
            end
            if ((k % D1 == 0) && (k < N1 * D1)) begin
                e = vec_q.pop_front();
                check("vec_step",  dut_in1, e.vec);
                check("err_run",   err1,    e.err_before);
            end
            if (k % D1 == D1 - 1) check("vec_hold", dut_in1, k / D1);
            if (k == N1 * D1 - 1) check("not_done_early", done1, 0);
        end
        r = sb_q.pop_front();
        check("fin_done",  done1,   1);
        check("fin_busy",  busy1,   0);
        check("fin_dutin", dut_in1, 0);
        check("fin_pass",  pass1,   r.pass);
        check("fin_err",   err1,    r.err);
        check("fin_ffv",   ffv1,    r.ffv);
        check("fin_ffvec", ffvec1,  r.ffvec);
    endtask

    // 3-input XOR run with start held high for the whole run
    task automatic run2();
        start2 = 1'b1;
        for (int k = 0; k <= N2 * D2; k++) begin
            @(posedge clk); #1;
            if ((k % D2 == 0) && (k < N2 * D2)) check("x_vec_step", dut_in2, k / D2);
            if (k == N2 * D2 - 1) check("x_not_done_early", done2, 0);
            if (k > 0 && k < N2 * D2) check("x_busy_held", busy2, 1);
        end
        start2 = 1'b0;
        check("x_done",  done2,  1);
        check("x_pass",  pass2,  1);
        check("x_err",   err2,   0);
        check("x_ffv",   ffv2,   0);
        check("x_dutin", dut_in2, 0);
        @(posedge clk); #1;
        check("x_done_hold", done2, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset1("rst");
        check("rst_busy2", busy2, 0);
        check("rst_done2", done2, 0);

        run1(M_OR);
        run1(M_AND);
        run1(M_OR);      // restart from DONE with err_count=2
        run1(M_STUCK);
        run2();

        // Mid-run reset while vector 2 is applied
        mode   = M_OR;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        begin
            int n;
            n = 0;
            while (dut_in1 != 2'd2 && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            check("wait_vec2", dut_in1, 2);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset1("midrst");
        @(posedge clk); #1;
        check("midrst_idle_busy", busy1, 0);
        run1(M_OR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
